mem_arbiter: RTL and testbench

//   Sole owner of the byte-wide RAM bus. Shares that bus between the instruction cache (word reads)
//   and the load/store unit (byte/half/word reads and writes). Serialises each request into byte

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Owns the byte-wide RAM bus, serving icache word reads and LSU byte/half/word loads and stores.
// Latency: grant cycle, then one beat per byte (+1 capture cycle for reads); stalls on rdy=0 or full I/O buffer.
module mem_arbiter #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = 32'h30000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              valid_from_inst_cache,
    input  logic [ADDR_W-1:0] addr_from_inst_cache,
    output logic              next_cycle_ready_to_inst_cache,
    output logic [31:0]       data_to_inst_cache,
    input  logic              valid_from_load_store,
    input  logic [ADDR_W-1:0] addr_from_load_store,
    input  logic              is_write_from_load_store,
    input  logic [1:0]        size_from_load_store,
    input  logic              signed_from_load_store,
    input  logic [31:0]       data_from_load_store,
    output logic              next_cycle_ready_to_load_store,
    output logic [31:0]       data_to_load_store
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_LS = 1'b1;

    state_t            state;
    logic              last_grant;
    logic              owner;
    logic [ADDR_W-1:0] base_addr;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [23:0]       wdata_hi;
    logic [2:0]        cnt;
    logic [23:0]       rbuf;
    logic              wr_q;

    logic [2:0]  n_beats;
    logic [2:0]  last_idx;
    logic        stall;
    logic        read_done;
    logic        write_done;
    logic        pick_ls;
    logic [31:0] rword;
    logic [31:0] ld_ext;
    logic [7:0]  next_wbyte;

    assign n_beats    = (size_q == 2'd0) ? 3'd1 : (size_q == 2'd1) ? 3'd2 : 3'd4;
    assign last_idx   = n_beats - 3'd1;
    assign stall      = (state == WRITE) && (base_addr >= IO_BASE) && io_buffer_full;
    assign read_done  = rdy && (state == READ) && !clear && (cnt == n_beats);
    assign write_done = rdy && (state == WRITE) && !stall && (cnt == last_idx);
    assign mem_wr     = rdy && wr_q && !stall;
    assign pick_ls    = valid_from_load_store && (!valid_from_inst_cache || last_grant == OWN_IC);

    assign next_cycle_ready_to_inst_cache = (read_done || write_done) && owner == OWN_IC;
    assign next_cycle_ready_to_load_store = (read_done || write_done) && owner == OWN_LS;

    // The final byte arrives on mem_din in the completion cycle and is merged here, not buffered.
    always_comb begin
        rword  = {mem_din, rbuf};
        ld_ext = {mem_din, rbuf};
        case (size_q)
            2'd0: begin
                rword  = {24'h0, mem_din};
                ld_ext = {{24{sgn_q & mem_din[7]}}, mem_din};
            end
            2'd1: begin
                rword  = {16'h0, mem_din, rbuf[7:0]};
                ld_ext = {{16{sgn_q & mem_din[7]}}, mem_din, rbuf[7:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (cnt)
            3'd0:    next_wbyte = wdata_hi[7:0];
            3'd1:    next_wbyte = wdata_hi[15:8];
            default: next_wbyte = wdata_hi[23:16];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            last_grant         <= OWN_LS;
            owner              <= OWN_IC;
            base_addr          <= '0;
            size_q             <= 2'd0;
            sgn_q              <= 1'b0;
            wdata_hi           <= '0;
            cnt                <= '0;
            rbuf               <= '0;
            wr_q               <= 1'b0;
            mem_a              <= '0;
            mem_dout           <= '0;
            data_to_inst_cache <= '0;
            data_to_load_store <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!clear && pick_ls) begin
                        owner      <= OWN_LS;
                        last_grant <= OWN_LS;
                        base_addr  <= addr_from_load_store;
                        mem_a      <= addr_from_load_store;
                        size_q     <= (size_from_load_store == 2'd3) ? 2'd2 : size_from_load_store;
                        sgn_q      <= signed_from_load_store;
                        wdata_hi   <= data_from_load_store[31:8];
                        mem_dout   <= data_from_load_store[7:0];
                        wr_q       <= is_write_from_load_store;
                        state      <= is_write_from_load_store ? WRITE : READ;
                    end else if (!clear && valid_from_inst_cache) begin
                        owner      <= OWN_IC;
                        last_grant <= OWN_IC;
                        base_addr  <= addr_from_inst_cache;
                        mem_a      <= addr_from_inst_cache;
                        size_q     <= 2'd2;
                        sgn_q      <= 1'b0;
                        wr_q       <= 1'b0;
                        state      <= READ;
                    end
                end
                READ: begin
                    if (clear) begin
                        state <= IDLE;
                    end else begin
                        case (cnt)
                            3'd1:    rbuf[7:0]   <= mem_din;
                            3'd2:    rbuf[15:8]  <= mem_din;
                            3'd3:    rbuf[23:16] <= mem_din;
                            default: ;
                        endcase
                        if (cnt == n_beats) begin
                            state <= IDLE;
                            if (owner == OWN_IC) data_to_inst_cache <= rword;
                            else                 data_to_load_store <= ld_ext;
                        end else begin
                            cnt <= cnt + 3'd1;
                            if (cnt + 3'd1 < n_beats)
                                mem_a <= base_addr + ADDR_W'(cnt) + ADDR_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (!stall) begin
                        if (cnt == last_idx) begin
                            state <= IDLE;
                            wr_q  <= 1'b0;
                        end else begin
                            cnt      <= cnt + 3'd1;
                            mem_a    <= base_addr + ADDR_W'(cnt) + ADDR_W'(1);
                            mem_dout <= next_wbyte;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model and per-port expected-data queues.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst, rdy, clear, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        valid_ic, valid_ls, is_write_ls, signed_ls;
    logic [31:0] addr_ic, addr_ls, data_ls, d_ic, d_ls;
    logic [1:0]  size_ls;
    logic        r_ic, r_ls;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    logic [31:0] exp_ic_q[$];
    logic [31:0] exp_ls_q[$];
    logic [7:0]  ram [0:262143];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .valid_from_inst_cache(valid_ic), .addr_from_inst_cache(addr_ic),
        .next_cycle_ready_to_inst_cache(r_ic), .data_to_inst_cache(d_ic),
        .valid_from_load_store(valid_ls), .addr_from_load_store(addr_ls),
        .is_write_from_load_store(is_write_ls), .size_from_load_store(size_ls),
        .signed_from_load_store(signed_ls), .data_from_load_store(data_ls),
        .next_cycle_ready_to_load_store(r_ls), .data_to_load_store(d_ls)
    );

    // RAM answers the address presented in the previous cycle.
    always @(posedge clk) begin
        if (rst) begin
            ram[32'h20]  <= 8'h80; ram[32'h21]  <= 8'hF0;
            ram[32'h100] <= 8'h78; ram[32'h101] <= 8'h56;
            ram[32'h102] <= 8'h34; ram[32'h103] <= 8'h12;
            ram[32'h200] <= 8'h11; ram[32'h201] <= 8'h22;
            ram[32'h202] <= 8'h33; ram[32'h203] <= 8'h44;
        end else if (mem_wr) begin
            ram[mem_a[17:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[17:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    // Issue one load and check ready latency (negedges from the grant cycle) and returned data.
    task automatic load(input bit ls, input logic [31:0] a, input logic [1:0] sz, input bit sg,
                        input int exp_lat, input logic [31:0] exp_dat, input string tag);
        bit got;
        int lat;
        logic [31:0] exp_v;
        got = 1'b0;
        lat = -1;
        if (ls) exp_ls_q.push_back(exp_dat); else exp_ic_q.push_back(exp_dat);
        drive_edge();
        if (ls) begin
            valid_ls = 1'b1; addr_ls = a; is_write_ls = 1'b0; size_ls = sz; signed_ls = sg;
        end else begin
            valid_ic = 1'b1; addr_ic = a;
        end
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (ls ? r_ls : r_ic) begin
                got = 1'b1;
                lat = i;
            end
        end
        check({tag, "_ready_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        drive_edge();
        valid_ls = 1'b0;
        valid_ic = 1'b0;
        @(negedge clk);
        exp_v = ls ? exp_ls_q.pop_front() : exp_ic_q.pop_front();
        check({tag, "_data"}, ls ? d_ls : d_ic, exp_v);
    endtask

    initial begin
        int order[4];
        int npulse;
        int pulses;
        bit pend_ic, pend_ls;
        logic [7:0] swb[4];
        logic [31:0] v;
        swb = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        valid_ic = 1'b0; addr_ic = '0; valid_ls = 1'b0; addr_ls = '0;
        is_write_ls = 1'b0; size_ls = 2'd0; signed_ls = 1'b0; data_ls = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_dout", 32'(mem_dout), 32'h0);
        check("rst_mem_wr", 32'(mem_wr), 32'h0);
        check("rst_ready", {30'h0, r_ic, r_ls}, 32'h0);
        check("rst_data_ic", d_ic, 32'h0);
        check("rst_data_ls", d_ls, 32'h0);

        // icache word read, beat by beat
        exp_ic_q.push_back(32'h12345678);
        drive_edge();
        valid_ic = 1'b1; addr_ic = 32'h100;
        @(negedge clk);
        check("ic_grant_ready", 32'(r_ic), 32'h0);
        check("ic_grant_wr", 32'(mem_wr), 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ic_beat_addr", mem_a, 32'h100 + 32'(k));
            check("ic_beat_ready", {31'h0, r_ic}, 32'h0);
        end
        @(negedge clk);
        check("ic_T4_ready", 32'(r_ic), 32'h1);
        drive_edge();
        valid_ic = 1'b0;
        @(negedge clk);
        v = exp_ic_q.pop_front();
        check("ic_T5_data", d_ic, v);

        load(1'b1, 32'h20, 2'd0, 1'b1, 2, 32'hFFFFFF80, "lb");
        load(1'b1, 32'h20, 2'd0, 1'b0, 2, 32'h00000080, "lbu");
        load(1'b1, 32'h20, 2'd1, 1'b1, 3, 32'hFFFFF080, "lh");
        load(1'b1, 32'h102, 2'd1, 1'b1, 3, 32'h00001234, "lh_pos");
        load(1'b1, 32'h100, 2'd3, 1'b0, 5, 32'h12345678, "size3");

        // sh 0xBEEF @0x40
        drive_edge();
        valid_ls = 1'b1; addr_ls = 32'h40; is_write_ls = 1'b1; size_ls = 2'd1; data_ls = 32'h0000BEEF;
        @(negedge clk);
        check("sh_grant_wr", 32'(mem_wr), 32'h0);
        @(negedge clk);
        check("sh_T0", {mem_a[15:0], 7'h0, mem_wr, mem_dout}, {16'h0040, 7'h0, 1'b1, 8'hEF});
        check("sh_T0_ready", 32'(r_ls), 32'h0);
        @(negedge clk);
        check("sh_T1", {mem_a[15:0], 7'h0, mem_wr, mem_dout}, {16'h0041, 7'h0, 1'b1, 8'hBE});
        check("sh_T1_ready", 32'(r_ls), 32'h1);
        drive_edge();
        valid_ls = 1'b0;
        @(negedge clk);
        check("sh_T2_wr", 32'(mem_wr), 32'h0);
        load(1'b1, 32'h40, 2'd1, 1'b0, 3, 32'h0000BEEF, "lhu_back");

        // both requesting continuously; LSU was granted last
        exp_ic_q.push_back(32'h12345678); exp_ic_q.push_back(32'h12345678);
        exp_ls_q.push_back(32'h0000BEEF); exp_ls_q.push_back(32'h0000BEEF);
        drive_edge();
        valid_ic = 1'b1; addr_ic = 32'h100;
        valid_ls = 1'b1; addr_ls = 32'h40; is_write_ls = 1'b0; size_ls = 2'd2; signed_ls = 1'b0;
        npulse = 0; pend_ic = 1'b0; pend_ls = 1'b0;
        for (int i = 0; i < 200 && npulse < 4; i++) begin
            @(negedge clk);
            if (pend_ic) begin v = exp_ic_q.pop_front(); check("rr_ic_data", d_ic, v); pend_ic = 1'b0; end
            if (pend_ls) begin v = exp_ls_q.pop_front(); check("rr_ls_data", d_ls, v); pend_ls = 1'b0; end
            if (r_ic && r_ls) check("rr_both_ready", 32'h1, 32'h0);
            if (r_ic) begin order[npulse] = 0; npulse++; pend_ic = 1'b1; end
            else if (r_ls) begin order[npulse] = 1; npulse++; pend_ls = 1'b1; end
        end
        check("rr_pulses", 32'(npulse), 32'd4);
        for (int i = 0; i < 4; i++) check("rr_order", 32'(order[i]), 32'(i % 2));
        drive_edge();
        valid_ic = 1'b0; valid_ls = 1'b0;
        @(negedge clk);
        if (pend_ic) begin v = exp_ic_q.pop_front(); check("rr_ic_data", d_ic, v); end
        if (pend_ls) begin v = exp_ls_q.pop_front(); check("rr_ls_data", d_ls, v); end

        // I/O store held off by a full buffer for five cycles
        drive_edge();
        io_buffer_full = 1'b1;
        valid_ls = 1'b1; addr_ls = 32'h30000; is_write_ls = 1'b1; size_ls = 2'd0; data_ls = 32'h41;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("io_stall", {30'h0, mem_wr, r_ls}, 32'h0);
        end
        drive_edge();
        io_buffer_full = 1'b0;
        @(negedge clk);
        check("io_write", {mem_a, 7'h0, mem_wr, r_ls}, {32'h30000, 7'h0, 1'b1, 1'b1});
        check("io_dout", 32'(mem_dout), 32'h41);
        drive_edge();
        valid_ls = 1'b0;
        @(negedge clk);
        check("io_after_wr", 32'(mem_wr), 32'h0);
        check("io_ram", 32'(ram[32'h30000]), 32'h41);

        // clear in T2 of an icache read abandons it
        drive_edge();
        valid_ic = 1'b1; addr_ic = 32'h200;
        repeat (3) @(negedge clk);
        drive_edge();
        clear = 1'b1;
        @(negedge clk);
        drive_edge();
        clear = 1'b0; valid_ic = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (r_ic) pulses++;
        end
        check("clear_no_ready", 32'(pulses), 32'h0);
        check("clear_data_kept", d_ic, 32'h12345678);
        load(1'b0, 32'h200, 2'd2, 1'b0, 5, 32'h44332211, "ic_after_clear");

        // clear during a word store is ignored
        drive_edge();
        valid_ls = 1'b1; addr_ls = 32'h80; is_write_ls = 1'b1; size_ls = 2'd2; data_ls = 32'hCAFEF00D;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin drive_edge(); clear = 1'b1; end
            if (k == 2) begin drive_edge(); clear = 1'b0; end
            @(negedge clk);
            check("sw_beat", {mem_a[15:0], 7'h0, mem_wr, mem_dout}, {16'h0080 + 16'(k), 7'h0, 1'b1, swb[k]});
            check("sw_ready", 32'(r_ls), (k == 3) ? 32'h1 : 32'h0);
        end
        drive_edge();
        valid_ls = 1'b0;
        load(1'b1, 32'h80, 2'd2, 1'b0, 5, 32'hCAFEF00D, "lw_back");

        // rdy low freezes a byte store mid-flight
        drive_edge();
        valid_ls = 1'b1; addr_ls = 32'h50; is_write_ls = 1'b1; size_ls = 2'd0; data_ls = 32'h5A;
        @(negedge clk);
        drive_edge();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("frz", {mem_a[29:0], mem_wr, r_ls}, {30'h50, 1'b0, 1'b0});
        end
        drive_edge();
        rdy = 1'b1;
        @(negedge clk);
        check("frz_release", {30'h0, mem_wr, r_ls}, 32'h3);
        drive_edge();
        valid_ls = 1'b0;
        @(negedge clk);
        check("frz_ram", 32'(ram[32'h50]), 32'h5A);

        // reset in the middle of a read
        drive_edge();
        valid_ic = 1'b1; addr_ic = 32'h100;
        repeat (3) @(negedge clk);
        drive_edge();
        rst = 1'b1; valid_ic = 1'b0;
        drive_edge();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_bus", {mem_a[22:0], mem_dout, mem_wr}, 32'h0);
        check("mrst_ready", {30'h0, r_ic, r_ls}, 32'h0);
        check("mrst_data", d_ic | d_ls, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
